// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer
// Takes parallel words over a valid/ready handshake and shifts them out
// MSB-first on x, one bit per clock, with zero gap between back-to-back
// words. Alongside the line it tracks the last two line bits and
// produces exp_y, the output a Mealy detector for PATTERN would give on
// the same cycle, so a bench can compare detector and golden directly.
//
// Optional feature: define SER_MATCH_CNT_EN to add clr_cnt / match_cnt,
// a saturating 16-bit count of cycles where exp_y was high.
module seq_bit_serializer #(
    parameter int          WIDTH   = 8,
    parameter logic [2:0]  PATTERN = 3'b101
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             exp_y
`ifdef SER_MATCH_CNT_EN
    ,
    input  logic             clr_cnt,
    output logic [15:0]      match_cnt
`endif
);

    localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [1:0]       hist;
    logic             last_bit;
    logic             accept;

    // Handshake and line outputs depend on state and bit_cnt only, so
    // din_ready never combinationally follows din_valid.
    assign last_bit  = (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign din_ready = (state == IDLE) || last_bit;
    assign accept    = din_ready && din_valid;
    assign busy      = (state == SHIFT);
    assign x_valid   = (state == SHIFT);
    assign x         = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;

    // Golden Mealy output: two-bit history plus the bit on the line now.
    assign exp_y     = (hist == PATTERN[2:1]) && (x == PATTERN[0]);

    // State, shift register and bit counter; reset drops any word in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // Next-state: load on accept (from IDLE or on the last bit), else shift.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = SHIFT;
                    shreg_nxt   = din;
                    bit_cnt_nxt = '0;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (accept) begin
                        shreg_nxt   = din;
                        bit_cnt_nxt = '0;
                    end else begin
                        state_nxt   = IDLE;
                        shreg_nxt   = '0;
                        bit_cnt_nxt = '0;
                    end
                end else begin
                    shreg_nxt   = {shreg[WIDTH-2:0], 1'b0};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Line history runs every cycle; idle zeros are part of the line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= 2'b00;
        end else begin
            hist <= {hist[0], x};
        end
    end

`ifdef SER_MATCH_CNT_EN
    // Saturating match counter; clear wins over a same-edge increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_cnt <= '0;
        end else if (clr_cnt) begin
            match_cnt <= '0;
        end else if (exp_y && (match_cnt != 16'hFFFF)) begin
            match_cnt <= match_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer (WIDTH=8, PATTERN=101).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// at that same point, well away from the next edge.
module tb_seq_bit_serializer;

    logic        clk;
    logic        reset_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        x;
    logic        x_valid;
    logic        busy;
    logic        exp_y;
    logic        clr_cnt;
    logic [15:0] match_cnt;

    int checks;
    int failures;

    seq_bit_serializer #(
        .WIDTH   (8),
        .PATTERN (3'b101)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .busy      (busy),
        .exp_y     (exp_y)
`ifdef SER_MATCH_CNT_EN
        ,
        .clr_cnt   (clr_cnt),
        .match_cnt (match_cnt)
`endif
    );

`ifndef SER_MATCH_CNT_EN
    assign match_cnt = 16'h0000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_cnt;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        idle(2);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (x !== 1'b0 || x_valid !== 1'b0 || din_ready !== 1'b1 ||
                exp_y !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got x=%b xv=%b rdy=%b y=%b busy=%b want 0 0 1 0 0",
                         i, x, x_valid, din_ready, exp_y, busy);
            end
            tick();
        end
`ifdef SER_MATCH_CNT_EN
        checks++;
        if (match_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL reset_cnt got %h want 0000", match_cnt);
        end
`endif
    endtask

    task automatic test_single;
        logic [7:0] w;
        logic       ey;
        w = 8'hA5;
        clear_cnt();
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ey = (i == 2) || (i == 7);
            checks++;
            if (x !== w[7-i] || x_valid !== 1'b1 || busy !== 1'b1 ||
                exp_y !== ey || din_ready !== (i == 7)) begin
                failures++;
                $display("FAIL single cyc=%0d got x=%b xv=%b busy=%b y=%b rdy=%b want x=%b 1 1 y=%b rdy=%b",
                         i + 1, x, x_valid, busy, exp_y, din_ready, w[7-i], ey, (i == 7));
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || x !== 1'b0 || x_valid !== 1'b0 || din_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_end got busy=%b x=%b xv=%b rdy=%b want 0 0 0 1",
                     busy, x, x_valid, din_ready);
        end
`ifdef SER_MATCH_CNT_EN
        checks++;
        if (match_cnt !== 16'd2) begin
            failures++;
            $display("FAIL single_cnt got %0d want 2", match_cnt);
        end
`endif
        idle(3);
    endtask

    task automatic test_back_to_back;
        logic [7:0] w;
        logic       ey;
        w = 8'hA5;
        clear_cnt();
        din = w;
        din_valid = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            ey = (i == 2) || (i == 7) || (i == 10) || (i == 15);
            checks++;
            if (x !== w[7-(i%8)] || x_valid !== 1'b1 || exp_y !== ey ||
                din_ready !== ((i % 8) == 7)) begin
                failures++;
                $display("FAIL b2b cyc=%0d got x=%b xv=%b y=%b rdy=%b want x=%b 1 y=%b rdy=%b",
                         i + 1, x, x_valid, exp_y, din_ready, w[7-(i%8)], ey, ((i % 8) == 7));
            end
            tick();
            if (i == 7) din_valid = 1'b0;
        end
        checks++;
        if (busy !== 1'b0 || x_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got busy=%b xv=%b want 0 0", busy, x_valid);
        end
`ifdef SER_MATCH_CNT_EN
        checks++;
        if (match_cnt !== 16'd4) begin
            failures++;
            $display("FAIL b2b_cnt got %0d want 4", match_cnt);
        end
`endif
        idle(3);
    endtask

    task automatic test_idle_gap;
        logic [7:0] w;
        int         hits;
        hits = 0;
        w = 8'h01;
        clear_cnt();
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x !== w[7-i] || exp_y !== 1'b0) begin
                failures++;
                $display("FAIL gap_w1 cyc=%0d got x=%b y=%b want x=%b y=0", i + 1, x, exp_y, w[7-i]);
            end
            if (exp_y === 1'b1) hits++;
            tick();
        end
        // one idle cycle on the line, then the next word arrives
        checks++;
        if (busy !== 1'b0 || x !== 1'b0 || exp_y !== 1'b0) begin
            failures++;
            $display("FAIL gap_idle got busy=%b x=%b y=%b want 0 0 0", busy, x, exp_y);
        end
        w = 8'h80;
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x !== w[7-i] || exp_y !== (i == 0)) begin
                failures++;
                $display("FAIL gap_w2 cyc=%0d got x=%b y=%b want x=%b y=%b",
                         i + 1, x, exp_y, w[7-i], (i == 0));
            end
            if (exp_y === 1'b1) hits++;
            tick();
        end
        checks++;
        if (hits != 1) begin
            failures++;
            $display("FAIL gap_hits got %0d want 1", hits);
        end
`ifdef SER_MATCH_CNT_EN
        checks++;
        if (match_cnt !== 16'd1) begin
            failures++;
            $display("FAIL gap_cnt got %0d want 1", match_cnt);
        end
`endif
        idle(3);
    endtask

    task automatic test_reset_mid_word;
        din = 8'hFF;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        idle(3);
        // now on bit 4 of the word
        checks++;
        if (busy !== 1'b1 || x !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got busy=%b x=%b want 1 1", busy, x);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (x !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1 || x_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst got x=%b busy=%b rdy=%b xv=%b want 0 0 1 0",
                     x, busy, din_ready, x_valid);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (x !== 1'b0 || x_valid !== 1'b0 || busy !== 1'b0 || exp_y !== 1'b0) begin
                failures++;
                $display("FAIL mid_post cyc=%0d got x=%b xv=%b busy=%b y=%b want 0 0 0 0",
                         i, x, x_valid, busy, exp_y);
            end
        end
    endtask

`ifdef SER_MATCH_CNT_EN
    task automatic test_counter;
        logic [7:0] w;
        w = 8'hA5;
        clear_cnt();
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) clr_cnt = 1'b1;
            tick();
            clr_cnt = 1'b0;
        end
        checks++;
        if (match_cnt !== 16'd0) begin
            failures++;
            $display("FAIL cnt_clr_prio got %0d want 0", match_cnt);
        end
        idle(3);
        // saturation: preload to all-ones, then one match (8'h50 has one)
        @(negedge clk);
        force dut.match_cnt = 16'hFFFF;
        #1;
        release dut.match_cnt;
        @(posedge clk);
        #1;
        w = 8'h50;
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        idle(9);
        checks++;
        if (match_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL cnt_sat got %h want ffff", match_cnt);
        end
        idle(3);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_idle_gap();
        test_reset_mid_word();
`ifdef SER_MATCH_CNT_EN
        test_counter();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Transmit-side companion to the serial sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first on a single serial line `x`, one bit per clock, so the line can drive the detector's `x` input directly.
- Also produces `exp_y`, a golden expected-detector output for pattern PATTERN, cycle-aligned with the Mealy detector, so a bench can compare the two directly.

Parameters:
- WIDTH, 8, parallel word width in bits; minimum 2.
- PATTERN, 3'b101, 3-bit pattern; first-transmitted bit is the MSB.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word.
- din_ready  output  1  block can accept din this cycle.
- x  output  1  serial line; 0 whenever not shifting.
- x_valid  output  1  x carries a data bit this cycle.
- busy  output  1  block is in the SHIFT state.
- exp_y  output  1  expected Mealy detector output for the current x.
- clr_cnt  input  1  synchronous clear of match_cnt; present only with SER_MATCH_CNT_EN.
- match_cnt  output  16  expected-match counter; present only with SER_MATCH_CNT_EN.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; shift register, bit counter and 2-bit line history all cleared to 0.
  - Outputs: x=0, x_valid=0, busy=0, din_ready=1, exp_y=0, match_cnt=0.
  - Reset mid-word drops the word in flight; no partial completion after release.
- FSM states:
  - IDLE:
    - din_ready=1, x=0, x_valid=0.
    - A clock edge with din_valid=1 loads din into the shift register, sets bit_cnt=0 and moves to SHIFT.
  - SHIFT:
    - x = shreg[WIDTH-1], x_valid=1, busy=1.
    - Each edge shifts left by 1 and increments bit_cnt.
    - At bit_cnt==WIDTH-1, din_ready=1:
      - If din_valid=1 at that edge: load the new word, reset bit_cnt to 0, stay in SHIFT. Back-to-back words have zero gap cycles.
      - Otherwise: go to IDLE.
    - In all other SHIFT cycles, din_ready=0 and din is ignored.
- Latency: word accepted at edge t → its MSB appears on x in the cycle following t. A word occupies exactly WIDTH consecutive cycles.
- din_ready is combinational from state and bit_cnt only; it never depends on din_valid.
- Line history h[1:0] (h[1] older):
  - Updated every clock, including IDLE cycles: h <= {h[0], x}.
  - IDLE zeros are part of the line, exactly as the detector sees them.
- exp_y:
  - Combinational: exp_y = (h == PATTERN[2:1]) && (x == PATTERN[0]).
  - Overlapping matches are allowed.
  - Same cycle as the detector's Mealy output.
- din_valid held high while busy and not at the last bit: the word is held off, not lost. The source must keep din stable until the handshake.

Optional Feature:
- Macro SER_MATCH_CNT_EN.
- Defined:
  - Adds clr_cnt and match_cnt.
  - match_cnt increments by 1 on each clock edge where exp_y=1, saturating at 16'hFFFF.
  - clr_cnt=1 forces 0 at the edge and takes priority over a simultaneous increment.
  - Reset value 0.
- Undefined: both ports and the counter logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8, PATTERN=101):
- Reset then idle 5 cycles → x=0, x_valid=0, din_ready=1, exp_y=0 throughout.
- Send 8'hA5 after idle → x sequence 1,0,1,0,0,1,0,1 over cycles 1-8 after accept; exp_y=1 in cycles 3 and 8 only; match_cnt=2; FSM returns to IDLE.
- Send 8'hA5 twice back-to-back (din_valid held) → 16 contiguous x_valid cycles with no gap; exp_y=1 in cycles 3, 8, 11, 16; match_cnt=4.
- Boundary across an idle gap: 8'h01, one IDLE cycle, then 8'h80 → exp_y=1 on the first bit of the second word (history 1,0 then 1); total match_cnt=1.
- Reset mid-word: assert reset_n=0 during bit 4 of 8'hFF → x=0, busy=0, din_ready=1 immediately; after release, no further bits of 8'hFF appear.
- Counter control: 8'hA5 then clr_cnt=1 on the same edge as the final exp_y → match_cnt=0. Preload the counter to 16'hFFFF via a forced state, then one match → stays 16'hFFFF.
